// File: rtl/loader_pkg.sv
// Shared types and defaults for the instruction memory loader.
// State encoding and hold timing used by imem_loader and its bench.
package loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_HOLD,
        ST_RUN,
        ST_ERROR
    } state_t;

    localparam int RESET_HOLD_DEF = 4;
    localparam int HOLD_W = 8;

endpackage

// File: rtl/imem_loader_if.sv
// Instruction word stream from a program source into the loader.
// master drives words, slave (the loader) answers with in_ready.
interface imem_loader_if;

    logic        in_valid;
    logic [31:0] in_data;
    logic        in_last;
    logic        in_ready;

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        output in_ready
    );

endinterface

// File: rtl/hold_counter.sv
// Loadable down-counter that times the processor reset hold window.
// zero is asserted whenever the count has run out.
module hold_counter #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero
);

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/imem_loader.sv
// Streams a program into instruction memory while holding the core in reset,
// then releases the core after a fixed hold window.
module imem_loader
    import loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int RESET_HOLD = RESET_HOLD_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    imem_loader_if.slave          src,
    output logic                  imem_wren,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_data,
    output logic                  proc_reset,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow_err,
    output logic [ADDR_WIDTH:0]   word_count
);

    localparam logic [ADDR_WIDTH-1:0] PTR_MAX = '1;
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RESET_HOLD - 1);

    state_t                  state;
    state_t                  state_nx;
    logic [ADDR_WIDTH-1:0]   ptr;
    logic                    wr_pend;
    logic                    accept;
    logic                    restart;
    logic                    at_top;
    logic                    hold_load;
    logic                    hold_dec;
    logic                    hold_zero;
    logic [HOLD_W-1:0]       hold_count;

    assign accept  = src.in_valid && (state == ST_LOAD);
    assign restart = start && (state inside {ST_IDLE, ST_RUN, ST_ERROR});
    assign at_top  = (ptr == PTR_MAX);

    always_comb begin
        state_nx  = state;
        hold_load = 1'b0;
        unique case (state)
            ST_IDLE, ST_RUN, ST_ERROR: begin
                if (start) state_nx = ST_LOAD;
            end
            ST_LOAD: begin
                if (accept && src.in_last) begin
                    state_nx  = ST_HOLD;
                    hold_load = 1'b1;
                end else if (accept && at_top) begin
                    state_nx = ST_ERROR;
                end
            end
            ST_HOLD: begin
                if (hold_zero) state_nx = ST_RUN;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign hold_dec = (state == ST_HOLD) && !hold_zero;

    hold_counter #(.W(HOLD_W)) u_hold (
        .clock    (clock),
        .reset    (reset),
        .load     (hold_load),
        .load_val (HOLD_INIT),
        .dec      (hold_dec),
        .count    (hold_count),
        .zero     (hold_zero)
    );

    // The pointer saturates at the top address so an overflow never wraps.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            ptr        <= '0;
            word_count <= '0;
            wr_pend    <= 1'b0;
            imem_addr  <= '0;
            imem_data  <= '0;
        end else begin
            state   <= state_nx;
            wr_pend <= accept;
            if (accept) begin
                imem_addr  <= ptr;
                imem_data  <= src.in_data;
                word_count <= word_count + 1'b1;
                if (!at_top) ptr <= ptr + 1'b1;
            end else if (restart) begin
                ptr        <= '0;
                word_count <= '0;
            end
        end
    end

    // A write already pending when reset rises must not reach memory.
    assign imem_wren    = wr_pend && !reset;
    assign src.in_ready = (state == ST_LOAD);
    assign proc_reset   = (state != ST_RUN);
    assign busy         = (state == ST_LOAD) || (state == ST_HOLD);
    assign done         = (state == ST_RUN);
    assign overflow_err = (state == ST_ERROR);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a default-width instance and a
// 2-bit-address instance share one stimulus stream.
module tb_imem_loader;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        valid;
    logic [31:0] data;
    logic        last;

    imem_loader_if if_a ();
    imem_loader_if if_b ();

    assign if_a.in_valid = valid;
    assign if_a.in_data  = data;
    assign if_a.in_last  = last;
    assign if_b.in_valid = valid;
    assign if_b.in_data  = data;
    assign if_b.in_last  = last;

    logic        wren_a, prst_a, busy_a, done_a, ovf_a;
    logic [11:0] addr_a;
    logic [31:0] wdat_a;
    logic [12:0] wc_a;
    logic        wren_b, prst_b, busy_b, done_b, ovf_b;
    logic [1:0]  addr_b;
    logic [31:0] wdat_b;
    logic [2:0]  wc_b;

    imem_loader dut_a (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .src          (if_a.slave),
        .imem_wren    (wren_a),
        .imem_addr    (addr_a),
        .imem_data    (wdat_a),
        .proc_reset   (prst_a),
        .busy         (busy_a),
        .done         (done_a),
        .overflow_err (ovf_a),
        .word_count   (wc_a)
    );

    imem_loader #(.ADDR_WIDTH(2)) dut_b (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .src          (if_b.slave),
        .imem_wren    (wren_b),
        .imem_addr    (addr_b),
        .imem_data    (wdat_b),
        .proc_reset   (prst_b),
        .busy         (busy_b),
        .done         (done_b),
        .overflow_err (ovf_b),
        .word_count   (wc_b)
    );

    always #5 clock = ~clock;

    logic [43:0] wq_a[$];
    logic [43:0] wq_b[$];

    always @(negedge clock) begin
        if (wren_a) wq_a.push_back({addr_a, wdat_a});
        if (wren_b) wq_b.push_back({10'd0, addr_b, wdat_b});
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic feed(input logic [31:0] d, input logic l);
        valid = 1'b1;
        data  = d;
        last  = l;
        tick();
        valid = 1'b0;
        last  = 1'b0;
    endtask

    task automatic chk_wr(input string tag, input logic [43:0] q[$],
                          input logic [31:0] d[$]);
        chk({tag, "_n"}, 64'(q.size()), 64'(d.size()));
        for (int i = 0; i < q.size() && i < d.size(); i++) begin
            chk($sformatf("%s_addr%0d", tag, i), 64'(q[i][43:32]), 64'(i));
            chk($sformatf("%s_data%0d", tag, i), 64'(q[i][31:0]), 64'(d[i]));
        end
    endtask

    logic [31:0] exp_d[$];

    initial begin
        reset = 1'b1;
        start = 1'b0;
        valid = 1'b0;
        data  = '0;
        last  = 1'b0;
        tick();
        tick();
        chk("rst_a_flags", {prst_a, if_a.in_ready, wren_a, busy_a, done_a, ovf_a},
            6'b100000);
        chk("rst_a_addr", 64'(addr_a), 0);
        chk("rst_a_data", 64'(wdat_a), 0);
        chk("rst_a_wc", 64'(wc_a), 0);
        chk("rst_b_flags", {prst_b, if_b.in_ready, wren_b, busy_b, done_b, ovf_b},
            6'b100000);
        reset = 1'b0;
        tick();

        // Basic load with start pulses in LOAD and HOLD
        exp_d = '{32'h28400005, 32'h28800003, 32'h00C22000, 32'h28C60000};
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t1_busy", {busy_a, if_a.in_ready, prst_a}, 3'b111);
        feed(exp_d[0], 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t1_start_in_load", {64'(wc_a), 1'b0, if_a.in_ready}, {64'd1, 2'b01});
        for (int i = 1; i < 4; i++) feed(exp_d[i], i == 3);
        chk("t1_hold_entry", {busy_a, prst_a, done_a}, 3'b110);
        for (int k = 1; k <= 4; k++) begin
            start = (k == 2);
            tick();
            start = 1'b0;
            chk($sformatf("t1_prst_k%0d", k), 64'(prst_a), 64'(k < 4));
        end
        chk("t1_done", {done_a, busy_a, ovf_a}, 3'b100);
        chk("t1_wc", 64'(wc_a), 4);
        chk_wr("t1_wr", wq_a, exp_d);

        // in_valid outside LOAD is ignored
        valid = 1'b1;
        data  = 32'hDEADBEEF;
        tick();
        tick();
        valid = 1'b0;
        chk("t1_idle_valid_wc", 64'(wc_a), 4);
        chk("t1_idle_valid_wr", 64'(wq_a.size()), 4);

        // Restart from RUN, then a gappy 3-word load
        wq_a.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t2_restart", {prst_a, busy_a, done_a}, 3'b110);
        chk("t2_restart_wc", 64'(wc_a), 0);
        exp_d = '{32'hA0000001, 32'hB0000002, 32'hC0000003};
        for (int i = 0; i < 3; i++) begin
            feed(exp_d[i], i == 2);
            tick();
        end
        for (int k = 0; k < 5; k++) tick();
        chk("t2_done", 64'(done_a), 1);
        chk_wr("t2_wr", wq_a, exp_d);

        // Overflow on the 2-bit instance
        wq_b.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) feed(32'h10000000 + i, 1'b0);
        chk("t3_err", {ovf_b, if_b.in_ready, prst_b, done_b}, 4'b1010);
        chk("t3_wc", 64'(wc_b), 4);
        exp_d = '{32'h10000000, 32'h10000001, 32'h10000002, 32'h10000003};
        chk_wr("t3_wr", wq_b, exp_d);
        wq_b.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t3_clear", {ovf_b, busy_b, if_b.in_ready}, 3'b011);
        chk("t3_clear_wc", 64'(wc_b), 0);
        feed(32'h11111111, 1'b1);
        tick();
        exp_d = '{32'h11111111};
        chk_wr("t3_reload", wq_b, exp_d);
        for (int k = 0; k < 6; k++) tick();

        // Exactly filling the 2-bit memory with last on the final word
        wq_b.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_d = '{32'h20000000, 32'h20000001, 32'h20000002, 32'h20000003};
        for (int i = 0; i < 4; i++) feed(exp_d[i], i == 3);
        for (int k = 0; k < 5; k++) tick();
        chk("t4_done", {done_b, ovf_b, prst_b}, 3'b100);
        chk("t4_wc", 64'(wc_b), 4);
        chk_wr("t4_wr", wq_b, exp_d);

        // Reset right after the 2nd accepted word
        wq_a.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        feed(32'h30000000, 1'b0);
        valid = 1'b1;
        data  = 32'h30000001;
        tick();
        valid = 1'b0;
        reset = 1'b1;
        tick();
        chk("t5_flags", {prst_a, if_a.in_ready, wren_a, busy_a, done_a, ovf_a},
            6'b100000);
        chk("t5_addr", 64'(addr_a), 0);
        chk("t5_data", 64'(wdat_a), 0);
        chk("t5_wc", 64'(wc_a), 0);
        exp_d = '{32'h30000000};
        chk_wr("t5_wr", wq_a, exp_d);
        reset = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
